core_scoreboard: RTL and testbench

- Register-hazard producer-side companion to the ID-stage forwarding logic.
- Tracks destination registers of in-flight long-latency operations (mul/div, uncached loads) in a pending bitmap.
- Raises a stall for hazards that forwarding cannot cover: load-use, RAW/WAW on pending registers, and long-unit saturation.
- Sits beside ID; its stall output freezes PC/IF/ID and inserts a bubble into EX.

---
 rtl/core_scoreboard.sv | 91 +++++++++
 tb/tb_core_scoreboard.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scoreboard.sv
// Producer-side register scoreboard: tracks destinations of in-flight long-latency ops
// and stalls ID on load-use, RAW/WAW against pending registers, and long-unit saturation.
module core_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic [4:0]  ID_rd,
  input  logic        ID_reg_write,
  input  logic        ID_long,
  input  logic [4:0]  EX_rd,
  input  logic        EX_mem_read,
  input  logic        flush,
  input  logic        done_valid,
  input  logic [4:0]  done_rd,
  output logic        stall,
  output logic [31:0] pending,
  output logic [3:0]  outstanding,
  output logic        overflow_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [31:0] pending_q, pending_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        overflow_q, overflow_d;

  logic rs_hit, rt_hit;
  logic load_use, raw, waw, full;
  logic issue;

  // Every hazard term looks at the registered bitmap, so a completing register
  // still stalls its consumer in the completion cycle (WB forwarding covers it after).
  always_comb begin
    rs_hit   = ID_uses_rs && (ID_rs != 5'd0);
    rt_hit   = ID_uses_rt && (ID_rt != 5'd0);
    load_use = EX_mem_read && (EX_rd != 5'd0) &&
               ((rs_hit && (EX_rd == ID_rs)) || (rt_hit && (EX_rd == ID_rt)));
    raw      = (rs_hit && pending_q[ID_rs]) || (rt_hit && pending_q[ID_rt]);
    waw      = ID_reg_write && (ID_rd != 5'd0) && pending_q[ID_rd];
    full     = ID_long && (outstanding_q == MAX_CNT);
    stall    = ID_valid && !flush && (load_use || raw || waw || full);
    issue    = ID_valid && ID_long && !flush && !stall;
  end

  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    overflow_d    = overflow_q;

    if (done_valid && (done_rd != 5'd0)) begin
      pending_d[done_rd] = 1'b0;
    end
    if (issue && (ID_rd != 5'd0)) begin
      pending_d[ID_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    // A completion with nothing in flight is a protocol error: count holds, flag sticks.
    if (done_valid && (outstanding_q == 4'd0)) begin
      overflow_d = 1'b1;
    end
    if (issue && !done_valid) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!issue && done_valid && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pending      = pending_q;
  assign outstanding  = outstanding_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_core_scoreboard.sv
// Self-checking bench for core_scoreboard: combinational vector table, directed
// multi-cycle sequences, and randomized traffic against a queue-based reference model.
module tb_core_scoreboard;

  logic        clock;
  logic        reset;
  logic        ID_valid;
  logic [4:0]  ID_rs, ID_rt, ID_rd;
  logic        ID_uses_rs, ID_uses_rt, ID_reg_write, ID_long;
  logic [4:0]  EX_rd;
  logic        EX_mem_read;
  logic        flush;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic        stall;
  logic [31:0] pending;
  logic [3:0]  outstanding;
  logic        overflow_err;

  int total;
  int bad;

  core_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_rd(ID_rd), .ID_reg_write(ID_reg_write), .ID_long(ID_long),
    .EX_rd(EX_rd), .EX_mem_read(EX_mem_read), .flush(flush),
    .done_valid(done_valid), .done_rd(done_rd),
    .stall(stall), .pending(pending), .outstanding(outstanding),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ID_valid = 0; ID_rs = 0; ID_rt = 0; ID_uses_rs = 0; ID_uses_rt = 0;
    ID_rd = 0; ID_reg_write = 0; ID_long = 0; EX_rd = 0; EX_mem_read = 0;
    flush = 0; done_valid = 0; done_rd = 0;
  endtask

  task automatic long_op(input logic [4:0] rd);
    idle();
    ID_valid = 1; ID_long = 1; ID_reg_write = 1; ID_rd = rd;
  endtask

  // Reference model: the in-flight ops are a multiset of destination registers.
  logic [4:0] inflight[$];

  function automatic logic [31:0] model_bitmap();
    logic [31:0] b = '0;
    foreach (inflight[k]) if (inflight[k] != 5'd0) b[inflight[k]] = 1'b1;
    return b;
  endfunction

  function automatic logic model_stall();
    logic [31:0] p = model_bitmap();
    bit hazard = 0;
    if (!ID_valid || flush) return 1'b0;
    if (ID_uses_rs && ID_rs != 0 && (p[ID_rs] || (EX_mem_read && EX_rd == ID_rs))) hazard = 1;
    if (ID_uses_rt && ID_rt != 0 && (p[ID_rt] || (EX_mem_read && EX_rd == ID_rt))) hazard = 1;
    if (ID_reg_write && ID_rd != 0 && p[ID_rd]) hazard = 1;
    if (ID_long && inflight.size() == 4) hazard = 1;
    return hazard;
  endfunction

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] exrd;
    logic       exmr, fl;
    logic       exp_stall;
  } vec_t;

  vec_t tbl[8];

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1;
    #3;
    chk("reset_pending", pending, 32'h0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_overflow", 32'(overflow_err), 32'd0);
    #20;
    reset = 0;
    tick();

    // Load-use and gating vectors, all from empty scoreboard state.
    tbl[0] = '{1, 8, 0, 1, 0, 8, 1, 0, 1};
    tbl[1] = '{1, 8, 0, 0, 0, 8, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[3] = '{1, 3, 8, 1, 1, 8, 1, 0, 1};
    tbl[4] = '{0, 8, 0, 1, 0, 8, 1, 0, 0};
    tbl[5] = '{1, 8, 0, 1, 0, 8, 1, 1, 0};
    tbl[6] = '{1, 8, 0, 1, 0, 8, 0, 0, 0};
    tbl[7] = '{1, 8, 0, 1, 0, 9, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      idle();
      ID_valid = tbl[i].v; ID_rs = tbl[i].rs; ID_rt = tbl[i].rt;
      ID_uses_rs = tbl[i].urs; ID_uses_rt = tbl[i].urt;
      EX_rd = tbl[i].exrd; EX_mem_read = tbl[i].exmr; flush = tbl[i].fl;
      #1;
      $display("vec %0d stall=%0b expect=%0b", i, stall, tbl[i].exp_stall);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
    end
    idle();
    tick();

    // Long issue rd=5, then RAW on rt=5 through the completion cycle.
    long_op(5);
    #1 chk("issue5_stall", 32'(stall), 32'd0);
    tick();
    chk("issue5_pending", pending, 32'h20);
    chk("issue5_outstanding", 32'(outstanding), 32'd1);
    idle();
    ID_valid = 1; ID_uses_rt = 1; ID_rt = 5;
    #1 chk("raw5_stall_a", 32'(stall), 32'd1);
    tick();
    chk("raw5_stall_b", 32'(stall), 32'd1);
    done_valid = 1; done_rd = 5;
    #1 chk("raw5_stall_done", 32'(stall), 32'd1);
    tick();
    done_valid = 0;
    #1 chk("raw5_stall_after", 32'(stall), 32'd0);
    chk("raw5_pending", pending, 32'h0);
    chk("raw5_outstanding", 32'(outstanding), 32'd0);
    $display("seq raw done");

    // WAW on pending register 12.
    long_op(12);
    tick();
    idle();
    ID_valid = 1; ID_reg_write = 1; ID_rd = 12;
    #1 chk("waw12_stall", 32'(stall), 32'd1);
    ID_rd = 0;
    #1 chk("waw0_stall", 32'(stall), 32'd0);
    idle();
    done_valid = 1; done_rd = 12;
    tick();
    idle();
    $display("seq waw done");

    // Saturation at four outstanding ops.
    for (int r = 1; r <= 4; r++) begin
      long_op(5'(r));
      tick();
    end
    idle();
    #1 chk("sat_outstanding", 32'(outstanding), 32'd4);
    chk("sat_pending", pending, 32'h1E);
    long_op(9);
    #1 chk("sat_stall", 32'(stall), 32'd1);
    done_valid = 1; done_rd = 1;
    #1 chk("sat_stall_with_done", 32'(stall), 32'd1);
    tick();
    done_valid = 0;
    #1 chk("sat_stall_next", 32'(stall), 32'd0);
    tick();
    chk("sat_issue_outstanding", 32'(outstanding), 32'd4);
    chk("sat_issue_pending", pending, 32'h21C);
    $display("seq saturation done");

    // Simultaneous issue/done, then a flushed long op.
    idle(); done_valid = 1; done_rd = 9; tick();
    done_rd = 2; tick();
    long_op(6); done_valid = 1; done_rd = 3;
    #1 chk("simul_stall", 32'(stall), 32'd0);
    tick();
    chk("simul_pending", pending, 32'h50);
    chk("simul_outstanding", 32'(outstanding), 32'd2);
    long_op(7); flush = 1;
    #1 chk("flush_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_pending", pending, 32'h50);
    chk("flush_outstanding", 32'(outstanding), 32'd2);
    idle(); done_valid = 1; done_rd = 4; tick();
    done_rd = 6; tick();
    idle();
    chk("drain_outstanding", 32'(outstanding), 32'd0);
    $display("seq simul/flush done");

    // Spurious completion sets the sticky error.
    done_valid = 1; done_rd = 10;
    tick();
    done_valid = 0;
    chk("ovf_set", 32'(overflow_err), 32'd1);
    chk("ovf_outstanding", 32'(outstanding), 32'd0);
    tick();
    chk("ovf_sticky", 32'(overflow_err), 32'd1);

    // Asynchronous reset mid-run, sampled before any clock edge.
    long_op(11);
    tick();
    idle();
    chk("pre_reset_pending", pending, 32'h800);
    reset = 1;
    #1;
    chk("areset_pending", pending, 32'h0);
    chk("areset_outstanding", 32'(outstanding), 32'd0);
    chk("areset_overflow", 32'(overflow_err), 32'd0);
    reset = 0;
    tick();
    $display("seq reset done");

    // Randomized traffic with out-of-order completion.
    inflight.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   pick;
      logic exp_st, exp_issue;
      idle();
      ID_valid     = ($urandom_range(0, 7) != 0);
      ID_rs        = 5'($urandom_range(0, 7));
      ID_rt        = 5'($urandom_range(0, 7));
      ID_uses_rs   = 1'($urandom_range(0, 1));
      ID_uses_rt   = 1'($urandom_range(0, 1));
      ID_rd        = 5'($urandom_range(0, 7));
      ID_long      = ($urandom_range(0, 2) == 0);
      ID_reg_write = ID_long ? 1'b1 : 1'($urandom_range(0, 1));
      EX_rd        = 5'($urandom_range(0, 7));
      EX_mem_read  = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      pick = -1;
      if (inflight.size() != 0 && $urandom_range(0, 2) == 0) begin
        pick = int'($urandom_range(0, inflight.size() - 1));
        done_valid = 1;
        done_rd = inflight[pick];
      end
      exp_st    = model_stall();
      exp_issue = ID_valid && ID_long && !flush && !exp_st;
      #1;
      chk("rand_stall", 32'(stall), 32'(exp_st));
      tick();
      if (pick >= 0) inflight.delete(pick);
      if (exp_issue) inflight.push_back(ID_rd);
      chk("rand_pending", pending, model_bitmap());
      chk("rand_outstanding", 32'(outstanding), 32'(inflight.size()));
      chk("rand_overflow", 32'(overflow_err), 32'd0);
      $display("rand %0d stall=%0b pending=%08h outstanding=%0d", cyc, stall, pending, outstanding);
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
